// File: rtl/store_commit_queue.sv
// Store commit queue: in-order store buffer linking dispatch, execute write-back, ROB retire and D-cache drain.
// Store-to-load forwarding is compiled in when the STORE_FWD_EN macro is defined.
module store_commit_queue #(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 3,
  parameter int EXEC_W = 2,
  parameter int RET_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int RC_W  = $clog2(RET_W + 1),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DISP_W-1:0]        disp_valid,
  output logic [CNT_W-1:0]         disp_free,
  output logic [DISP_W*IDX_W-1:0]  disp_idx,
  input  logic [EXEC_W-1:0]        exec_valid,
  input  logic [EXEC_W*IDX_W-1:0]  exec_idx,
  input  logic [EXEC_W*ADDR_W-1:0] exec_addr,
  input  logic [EXEC_W*DATA_W-1:0] exec_data,
  input  logic [RC_W-1:0]          retire_count,
  input  logic                     mispredict,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  input  logic                     mem_req_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [PTR_W-1:0]         ld_age,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     fwd_stall,
  output logic                     empty
);

  localparam int AV_W = CNT_W + 1;

  typedef enum logic [1:0] {FREE, ALLOC, READY, COMMITTED} entry_state_e;

  entry_state_e      state_q [DEPTH];
  entry_state_e      state_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] commit_q, commit_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] disp_free_q, disp_free_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] head_idx, commit_idx, tail_idx;
  logic [PTR_W-1:0] disp_cnt;
  logic [PTR_W-1:0] occ_d;
  logic [AV_W-1:0]  disp_avail;
  logic             drain;
  logic             disp_accept;
  logic             retire_bad;

  assign head_idx   = head_q[IDX_W-1:0];
  assign commit_idx = commit_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];

  assign mem_req_valid = (state_q[head_idx] == COMMITTED);
  assign mem_req_addr  = addr_q[head_idx];
  assign mem_req_data  = data_q[head_idx];
  assign drain         = mem_req_valid && mem_req_ready;

  assign disp_free = disp_free_q;
  assign empty     = empty_q;

  always_comb begin
    disp_idx = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_idx[i*IDX_W +: IDX_W] = tail_idx + IDX_W'(i);
    end
  end

  // An entry released by this cycle's drain may be reused by dispatch in the same cycle.
  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_cnt = disp_cnt + PTR_W'(disp_valid[i]);
    end
    disp_avail  = AV_W'(disp_free_q) + AV_W'(drain);
    disp_accept = !mispredict && (AV_W'(disp_cnt) <= disp_avail);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    head_d   = head_q;
    commit_d = commit_q;
    tail_d   = tail_q;

    if (drain) begin
      state_d[head_idx] = FREE;
      head_d = head_q + 1'b1;
    end

    for (int p = 0; p < EXEC_W; p++) begin
      if (exec_valid[p] && state_q[exec_idx[p*IDX_W +: IDX_W]] == ALLOC) begin
        state_d[exec_idx[p*IDX_W +: IDX_W]] = READY;
        addr_d[exec_idx[p*IDX_W +: IDX_W]]  = exec_addr[p*ADDR_W +: ADDR_W];
        data_d[exec_idx[p*IDX_W +: IDX_W]]  = exec_data[p*DATA_W +: DATA_W];
      end
    end

    for (int i = 0; i < RET_W; i++) begin
      if (i < int'(retire_count)) begin
        state_d[commit_idx + IDX_W'(i)] = COMMITTED;
      end
    end
    commit_d = commit_q + PTR_W'(retire_count);

    // Squash sees the post-retire view, so stores retired this cycle survive.
    if (mispredict) begin
      tail_d = commit_d;
      for (int k = 0; k < DEPTH; k++) begin
        if (state_d[k] == ALLOC || state_d[k] == READY) begin
          state_d[k] = FREE;
        end
      end
    end else if (disp_accept) begin
      for (int i = 0; i < DISP_W; i++) begin
        if (disp_valid[i]) begin
          state_d[tail_idx + IDX_W'(i)] = ALLOC;
        end
      end
      tail_d = tail_q + disp_cnt;
    end

    occ_d       = tail_d - head_d;
    disp_free_d = CNT_W'(DEPTH) - CNT_W'(occ_d);
    empty_d     = (tail_d == head_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        state_q[k] <= FREE;
      end
      head_q      <= '0;
      commit_q    <= '0;
      tail_q      <= '0;
      disp_free_q <= CNT_W'(DEPTH);
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      commit_q    <= commit_d;
      tail_q      <= tail_d;
      disp_free_q <= disp_free_d;
      empty_q     <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    retire_bad = 1'b0;
    for (int i = 0; i < RET_W; i++) begin
      if (i < int'(retire_count) && state_q[commit_idx + IDX_W'(i)] != READY) begin
        retire_bad = 1'b1;
      end
    end
  end

  retire_ready_a: assert property (@(posedge clock) disable iff (reset) !retire_bad);

  // The load window runs from head up to ld_age-1; a distance beyond DEPTH means head already passed it.
  logic [PTR_W-1:0] ld_dist;
  assign ld_dist = ld_age - head_q;

`ifdef STORE_FWD_EN
  logic              any_alloc;
  logic              fwd_match;
  logic [DATA_W-1:0] fwd_match_data;

  always_comb begin
    any_alloc      = 1'b0;
    fwd_match      = 1'b0;
    fwd_match_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ld_dist <= PTR_W'(DEPTH) && PTR_W'(k) < ld_dist &&
          state_q[head_idx + IDX_W'(k)] != FREE) begin
        if (state_q[head_idx + IDX_W'(k)] == ALLOC) begin
          any_alloc = 1'b1;
        end else if (addr_q[head_idx + IDX_W'(k)] == ld_addr) begin
          fwd_match      = 1'b1;
          fwd_match_data = data_q[head_idx + IDX_W'(k)];
        end
      end
    end
    fwd_stall = any_alloc;
    fwd_hit   = !any_alloc && fwd_match;
    fwd_data  = (!any_alloc && fwd_match) ? fwd_match_data : '0;
  end
`else
  logic any_occ;
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;

  always_comb begin
    any_occ = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ld_dist <= PTR_W'(DEPTH) && PTR_W'(k) < ld_dist &&
          state_q[head_idx + IDX_W'(k)] != FREE) begin
        any_occ = 1'b1;
      end
    end
    fwd_stall = any_occ;
    fwd_hit   = 1'b0;
    fwd_data  = '0;
  end
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed self-checking bench for store_commit_queue: drain, full/wrap, squash, exec conflicts and load lookup.
// Runs the STORE_FWD_EN forwarding scenario when that macro is defined, the stall-only scenario otherwise.
module tb_store_commit_queue;

  localparam int DEPTH  = 16;
  localparam int DISP_W = 3;
  localparam int EXEC_W = 2;
  localparam int RET_W  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;
  localparam int RC_W   = 2;
  localparam int PTR_W  = 5;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [DISP_W-1:0]        disp_valid;
  logic [CNT_W-1:0]         disp_free;
  logic [DISP_W*IDX_W-1:0]  disp_idx;
  logic [EXEC_W-1:0]        exec_valid;
  logic [EXEC_W*IDX_W-1:0]  exec_idx;
  logic [EXEC_W*ADDR_W-1:0] exec_addr;
  logic [EXEC_W*DATA_W-1:0] exec_data;
  logic [RC_W-1:0]          retire_count;
  logic                     mispredict;
  logic                     mem_req_valid;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [DATA_W-1:0]        mem_req_data;
  logic                     mem_req_ready;
  logic [ADDR_W-1:0]        ld_addr;
  logic [PTR_W-1:0]         ld_age;
  logic                     fwd_hit;
  logic [DATA_W-1:0]        fwd_data;
  logic                     fwd_stall;
  logic                     empty;

  int errors = 0;
  int checks = 0;

  store_commit_queue #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .EXEC_W(EXEC_W),
    .RET_W(RET_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_free(disp_free), .disp_idx(disp_idx),
    .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr), .exec_data(exec_data),
    .retire_count(retire_count), .mispredict(mispredict),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .ld_addr(ld_addr), .ld_age(ld_age),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .empty(empty)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_inputs();
    disp_valid    = '0;
    exec_valid    = '0;
    exec_idx      = '0;
    exec_addr     = '0;
    exec_data     = '0;
    retire_count  = '0;
    mispredict    = 1'b0;
    mem_req_ready = 1'b0;
    ld_addr       = '0;
    ld_age        = '0;
  endtask

  // Advance one clock and land 1ns after the edge; per-cycle strobes drop afterwards.
  task automatic cycle();
    @(posedge clock);
    #1;
    disp_valid   = '0;
    exec_valid   = '0;
    retire_count = '0;
    mispredict   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_exec(input int port, input logic [IDX_W-1:0] idx,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    exec_valid[port] = 1'b1;
    exec_idx[port*IDX_W +: IDX_W]    = idx;
    exec_addr[port*ADDR_W +: ADDR_W] = addr;
    exec_data[port*DATA_W +: DATA_W] = data;
  endtask

  task automatic test_reset();
    do_reset();
    ld_age = 5'd5;
    #1;
    checks++; if (disp_free !== 5'd16) begin errors++; $display("[TB] FAIL rst_free: got %0d want 16", disp_free); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_empty: got %0b want 1", empty); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_memvalid: got %0b want 0", mem_req_valid); end
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_fwd: got hit=%0b stall=%0b want 0/0", fwd_hit, fwd_stall); end
    checks++; if (disp_idx !== 12'h210) begin errors++; $display("[TB] FAIL rst_dispidx: got %h want 210", disp_idx); end
  endtask

  task automatic test_commit_drain();
    do_reset();
    disp_valid = 3'b111;
    cycle();
    checks++; if (disp_free !== 5'd13 || empty !== 1'b0) begin errors++; $display("[TB] FAIL cd_disp: got free=%0d empty=%0b want 13/0", disp_free, empty); end
    set_exec(0, 4'd0, 32'h1000, 32'hD0);
    set_exec(1, 4'd1, 32'h1001, 32'hD1);
    cycle();
    set_exec(0, 4'd2, 32'h1002, 32'hD2);
    cycle();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL cd_ready_novalid: got %0b want 0", mem_req_valid); end
    retire_count = 2'd3;
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_data !== 32'hD0) begin
      errors++; $display("[TB] FAIL cd_req: got v=%0b a=%h d=%h want 1/1000/d0", mem_req_valid, mem_req_addr, mem_req_data); end
    cycle();
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || disp_free !== 5'd13) begin
      errors++; $display("[TB] FAIL cd_hold: got v=%0b a=%h free=%0d want 1/1000/13", mem_req_valid, mem_req_addr, disp_free); end
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mem_req_addr !== 32'h1000 + k || mem_req_data !== 32'hD0 + k) begin
        errors++; $display("[TB] FAIL cd_drain%0d: got a=%h d=%h want %h/%h", k, mem_req_addr, mem_req_data, 32'h1000 + k, 32'hD0 + k); end
      cycle();
    end
    mem_req_ready = 1'b0;
    checks++; if (disp_free !== 5'd16 || empty !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL cd_done: got free=%0d empty=%0b v=%0b want 16/1/0", disp_free, empty, mem_req_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      disp_valid = 3'b111;
      cycle();
    end
    disp_valid = 3'b001;
    cycle();
    checks++; if (disp_free !== 5'd0 || disp_idx[3:0] !== 4'd0) begin
      errors++; $display("[TB] FAIL fw_full: got free=%0d idx0=%0d want 0/0", disp_free, disp_idx[3:0]); end
    disp_valid = 3'b001;
    cycle();
    checks++; if (disp_free !== 5'd0 || disp_idx[3:0] !== 4'd0) begin
      errors++; $display("[TB] FAIL fw_reject: got free=%0d idx0=%0d want 0/0", disp_free, disp_idx[3:0]); end
    disp_valid = 3'b011;
    cycle();
    checks++; if (disp_free !== 5'd0 || disp_idx[3:0] !== 4'd0) begin
      errors++; $display("[TB] FAIL fw_reject2: got free=%0d idx0=%0d want 0/0", disp_free, disp_idx[3:0]); end
    set_exec(0, 4'd0, 32'h500, 32'h55);
    cycle();
    retire_count = 2'd1;
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin
      errors++; $display("[TB] FAIL fw_commit: got v=%0b a=%h want 1/500", mem_req_valid, mem_req_addr); end
    disp_valid    = 3'b001;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (disp_idx[3:0] !== 4'd0) begin errors++; $display("[TB] FAIL fw_wrapidx: got %0d want 0", disp_idx[3:0]); end
    cycle();
    mem_req_ready = 1'b0;
    checks++; if (disp_free !== 5'd0 || mem_req_valid !== 1'b0 || disp_idx[3:0] !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("[TB] FAIL fw_after: got free=%0d v=%0b idx0=%0d empty=%0b want 0/0/1/0", disp_free, mem_req_valid, disp_idx[3:0], empty); end
  endtask

  task automatic test_mispredict();
    do_reset();
    disp_valid = 3'b111;
    cycle();
    disp_valid = 3'b011;
    cycle();
    checks++; if (disp_free !== 5'd11) begin errors++; $display("[TB] FAIL mp_disp: got %0d want 11", disp_free); end
    set_exec(0, 4'd0, 32'h2000, 32'hE0);
    set_exec(1, 4'd1, 32'h2001, 32'hE1);
    cycle();
    set_exec(0, 4'd2, 32'h2002, 32'hE2);
    set_exec(1, 4'd3, 32'h2003, 32'hE3);
    cycle();
    set_exec(0, 4'd4, 32'h2004, 32'hE4);
    cycle();
    retire_count = 2'd2;
    mispredict   = 1'b1;
    disp_valid   = 3'b001;
    cycle();
    checks++; if (disp_free !== 5'd14 || disp_idx[3:0] !== 4'd2) begin
      errors++; $display("[TB] FAIL mp_squash: got free=%0d idx0=%0d want 14/2", disp_free, disp_idx[3:0]); end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
      errors++; $display("[TB] FAIL mp_head: got v=%0b a=%h want 1/2000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2001 || mem_req_data !== 32'hE1) begin
      errors++; $display("[TB] FAIL mp_drain2: got v=%0b a=%h d=%h want 1/2001/e1", mem_req_valid, mem_req_addr, mem_req_data); end
    cycle();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || empty !== 1'b1 || disp_free !== 5'd16) begin
      errors++; $display("[TB] FAIL mp_done: got v=%0b empty=%0b free=%0d want 0/1/16", mem_req_valid, empty, disp_free); end
  endtask

  task automatic test_exec_conflict();
    do_reset();
    disp_valid = 3'b111;
    cycle();
    disp_valid = 3'b011;
    cycle();
    set_exec(0, 4'd4, 32'h40, 32'h1);
    set_exec(1, 4'd4, 32'h40, 32'h2);
    cycle();
    set_exec(0, 4'd0, 32'h300, 32'h30);
    set_exec(1, 4'd4, 32'h99, 32'h3);
    cycle();
    set_exec(0, 4'd1, 32'h301, 32'h31);
    set_exec(1, 4'd2, 32'h302, 32'h32);
    cycle();
    set_exec(0, 4'd3, 32'h303, 32'h33);
    cycle();
    retire_count = 2'd3;
    cycle();
    retire_count = 2'd2;
    cycle();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] exp_a, exp_d;
      exp_a = (k == 4) ? 32'h40 : 32'h300 + k;
      exp_d = (k == 4) ? 32'h2  : 32'h30 + k;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_a || mem_req_data !== exp_d) begin
        errors++; $display("[TB] FAIL ex_entry%0d: got v=%0b a=%h d=%h want 1/%h/%h", k, mem_req_valid, mem_req_addr, mem_req_data, exp_a, exp_d); end
      cycle();
    end
    mem_req_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL ex_empty: got %0b want 1", empty); end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_forwarding();
    do_reset();
    disp_valid = 3'b111;
    cycle();
    set_exec(0, 4'd0, 32'h100, 32'hA);
    set_exec(1, 4'd1, 32'h100, 32'hB);
    cycle();
    set_exec(0, 4'd2, 32'h100, 32'hC);
    cycle();
    ld_addr = 32'h100;
    ld_age  = 5'd2;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB || fwd_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_age2: got h=%0b d=%h s=%0b want 1/b/0", fwd_hit, fwd_data, fwd_stall); end
    ld_age = 5'd3;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin
      errors++; $display("[TB] FAIL fwd_age3: got h=%0b d=%h want 1/c", fwd_hit, fwd_data); end
    ld_age = 5'd1;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hA) begin
      errors++; $display("[TB] FAIL fwd_age1: got h=%0b d=%h want 1/a", fwd_hit, fwd_data); end
    ld_addr = 32'h104;
    ld_age  = 5'd3;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_miss: got h=%0b s=%0b want 0/0", fwd_hit, fwd_stall); end
    do_reset();
    disp_valid = 3'b011;
    cycle();
    set_exec(0, 4'd0, 32'h100, 32'hA);
    cycle();
    ld_addr = 32'h100;
    ld_age  = 5'd2;
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_stall: got h=%0b s=%0b want 0/1", fwd_hit, fwd_stall); end
    ld_age = 5'd1;
    #1;
    checks++; if (fwd_stall !== 1'b0 || fwd_hit !== 1'b1 || fwd_data !== 32'hA) begin
      errors++; $display("[TB] FAIL fwd_older: got h=%0b d=%h s=%0b want 1/a/0", fwd_hit, fwd_data, fwd_stall); end
  endtask
`else
  task automatic test_load_stall();
    do_reset();
    disp_valid = 3'b011;
    cycle();
    set_exec(0, 4'd0, 32'h100, 32'hA);
    cycle();
    ld_addr = 32'h100;
    ld_age  = 5'd2;
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      errors++; $display("[TB] FAIL ls_stall: got h=%0b d=%h s=%0b want 0/0/1", fwd_hit, fwd_data, fwd_stall); end
    ld_age = 5'd0;
    #1;
    checks++; if (fwd_stall !== 1'b0) begin errors++; $display("[TB] FAIL ls_nowin: got %0b want 0", fwd_stall); end
    set_exec(0, 4'd1, 32'h100, 32'hB);
    cycle();
    ld_age = 5'd1;
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("[TB] FAIL ls_ready: got h=%0b s=%0b want 0/1", fwd_hit, fwd_stall); end
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_commit_drain();
    test_full_wrap();
    test_mispredict();
    test_exec_conflict();
`ifdef STORE_FWD_EN
    test_forwarding();
`else
    test_load_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_commit_queue.md
STORE_COMMIT_QUEUE -- requirements
Module: store_commit_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, at least 4.
REQ-002 Parameter DISP_W, default 3, dispatch slots per cycle.
REQ-003 Parameter EXEC_W, default 2, execute write-back ports.
REQ-004 Parameter RET_W, default 3, maximum retires per cycle.
REQ-005 Parameter ADDR_W, default 32, address width.
REQ-006 Parameter DATA_W, default 32, data width.
REQ-007 Derived widths: IDX_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1).
REQ-008 clock  input  1  single clock for the block; all state updates on posedge clock.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 disp_valid  input  DISP_W  dispatch requests; set bits are contiguous from bit 0.
REQ-011 disp_free  output  CNT_W  registered count of free entries.
REQ-012 disp_idx  output  DISP_W*IDX_W  slot i receives index (tail+i) mod DEPTH.
REQ-013 exec_valid, exec_idx, exec_addr, exec_data  input  EXEC_W, EXEC_W*IDX_W, EXEC_W*ADDR_W, EXEC_W*DATA_W  resolved store address and data.
REQ-014 retire_count  input  $clog2(RET_W+1)  number of oldest stores the ROB commits this cycle.
REQ-015 mispredict  input  1  squashes all non-committed entries.
REQ-016 mem_req_valid, mem_req_addr, mem_req_data  output  1, ADDR_W, DATA_W  D-cache write request.
REQ-017 mem_req_ready  input  1  D-cache accepts the request.
REQ-018 ld_addr, ld_age  input  ADDR_W, IDX_W+1  load lookup; ld_age is the tail snapshot taken at load dispatch.
REQ-019 fwd_hit, fwd_data, fwd_stall  output  1, DATA_W, 1  load lookup result; combinational from registered state.
REQ-020 empty  output  1  registered; high when no entry is occupied.

Function
REQ-021 Each entry's state SHALL be one of FREE, ALLOC, READY or COMMITTED.
REQ-022 Entry state transitions SHALL be: dispatch moves FREE to ALLOC; exec moves ALLOC to READY; retire moves READY to COMMITTED; a drain handshake moves COMMITTED to FREE.
REQ-023 Pointers head, commit and tail SHALL each be IDX_W+1 bits, the extra bit being a wrap bit; the queue is full when indices are equal and wrap bits differ, and empty when head equals tail.
REQ-024 Dispatch SHALL be all-or-nothing: when popcount(disp_valid) exceeds disp_free, the whole group is rejected and tail does not move.
REQ-025 An exec write SHALL update address and data only when the target entry is in ALLOC; writes to any other state are ignored; if two ports target the same index, the higher-numbered port wins.
REQ-026 Retire SHALL advance commit by retire_count; the entries covered are required to be READY, and an assertion fires otherwise.
REQ-027 mem_req_valid SHALL be high exactly when the head entry is COMMITTED; mem_req_addr and mem_req_data SHALL be held stable until mem_req_ready.
REQ-028 On mem_req_valid and mem_req_ready, head SHALL advance by one; at most one drain occurs per cycle.
REQ-029 disp_free SHALL equal DEPTH minus occupancy, where the next value reflects this cycle's drain, squash and dispatch.
REQ-030 On mispredict, retire SHALL be applied first; then tail is set to commit, ALLOC and READY entries become FREE, and dispatch that cycle is ignored.
REQ-031 On mispredict, COMMITTED entries and draining SHALL continue unaffected.
REQ-032 Drain, retire and dispatch in the same cycle SHALL all take effect, including across pointer wrap-around.

Reset
REQ-033 Reset SHALL set all entries to FREE, all pointers to 0, disp_free to DEPTH, empty to 1, mem_req_valid to 0, and fwd_hit and fwd_stall to 0 when the queue is empty.
REQ-034 Reset SHALL take priority over mispredict and all other inputs, including in the middle of a pending drain.

Configuration
REQ-035 The macro is STORE_FWD_EN.
REQ-036 When STORE_FWD_EN is defined, consider entries from head up to ld_age-1: if any is ALLOC, fwd_stall=1 and fwd_hit=0; otherwise the youngest entry with an address equal to ld_addr drives fwd_hit=1 and fwd_data with its data.
REQ-037 When STORE_FWD_EN is undefined, fwd_hit=0, fwd_data=0, and fwd_stall=1 whenever any occupied entry lies in the head to ld_age-1 range.

Verification
REQ-038 Reset, dispatch 3, exec all, retire 3, hold mem_req_ready=0 -> mem_req_valid=1, head and disp_free stay at DEPTH-3; then ready=1 for 3 cycles -> disp_free=16, empty=1.
REQ-039 Fill to 16, dispatch 1 more -> rejected, disp_free=0; drain 1 and dispatch 1 in the same cycle -> disp_idx wraps to 0, disp_free stays 0.
REQ-040 Dispatch 5, exec all, retire 2, mispredict -> tail=commit=2, disp_free=14, the 2 committed entries still drain.
REQ-041 (STORE_FWD_EN) Stores at entries 0 and 1, both addr 0x100, data 0xA and 0xB, load with ld_age=2 -> fwd_hit=1, fwd_data=0xB; entry 1 left ALLOC instead -> fwd_stall=1.
REQ-042 Exec ports 0 and 1 both target index 4, data 0x1 and 0x2 -> entry 4 holds 0x2; a repeated exec after READY is ignored.
